// File: rtl/mem_stg.sv
// mem_stg: MIPS memory stage; define MEM_STG_ALIGN_CHK_EN to trap misaligned half/word accesses
package exec_mem_pkg;
  typedef enum logic [1:0] {MEM_NONE, MEM_LD, MEM_ST} mem_op_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_sz_t;
  typedef struct packed {
    logic        jmp_vld;
    logic [31:0] addr;
    mem_op_t     mem_op;
    mem_sz_t     mem_sz;
    logic        sgnd;
    logic        dst_vld;
    logic [4:0]  dst_reg;
    logic [31:0] data;
  } exec_mem_pkt_t;
  typedef struct packed {
    logic        dst_vld;
    logic [4:0]  dst_reg;
    logic [31:0] data;
  } mem_wb_pkt_t;
  typedef struct packed {
    logic       dst_vld;
    logic [4:0] dst_reg;
    logic       ld_pend;
  } mem_haz_pkt_t;
endpackage

module mem_stg
  import exec_mem_pkg::*;
(
  input  logic          clk,
  input  logic          resetn,
  input  logic          exec_mem_vld,
  output logic          exec_mem_rdy,
  input  exec_mem_pkt_t exec_mem_pkt,
  output logic          dmem_req_vld,
  input  logic          dmem_req_rdy,
  output logic          dmem_req_we,
  output logic [31:0]   dmem_req_addr,
  output logic [3:0]    dmem_req_be,
  output logic [31:0]   dmem_req_wdata,
  input  logic          dmem_rsp_vld,
  input  logic [31:0]   dmem_rsp_data,
  output logic          mem_wb_vld,
  input  logic          mem_wb_rdy,
  output mem_wb_pkt_t   mem_wb_pkt,
  output mem_haz_pkt_t  mem_haz_pkt,
  output logic          mem_fet_redir_vld,
  output logic [31:0]   mem_fet_redir_addr,
  output logic          mem_exc_vld,
  output logic [31:0]   mem_exc_addr
);
  typedef enum logic [1:0] {IDLE, REQ, RSP, OUT} state_t;
  state_t state, state_d;
  exec_mem_pkt_t pkt_q;
  logic acc, mis, is_ld, acc_q;
  logic [1:0] a;
  logic [3:0] be;
  logic [7:0] rb;
  logic [15:0] rh;
  logic [31:0] ld_data, wdata;
  assign a = pkt_q.addr[1:0];
`ifdef MEM_STG_ALIGN_CHK_EN
  logic exc_q;
  assign mis = (pkt_q.mem_sz == SZ_H && a[0]) || (pkt_q.mem_sz == SZ_W && a != 2'b00);
  assign mem_exc_vld = exc_q;
  assign mem_exc_addr = exc_q ? pkt_q.addr : '0;
  // one-cycle trap pulse when a misaligned access is dropped in REQ
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) exc_q <= 1'b0;
    else exc_q <= state == REQ && mis;
`else
  assign mis = 1'b0;
  assign mem_exc_vld = 1'b0;
  assign mem_exc_addr = '0;
`endif
  assign is_ld = pkt_q.mem_op == MEM_LD;
  assign exec_mem_rdy = resetn && (state == IDLE || (state == OUT && mem_wb_rdy));
  assign acc = exec_mem_vld && exec_mem_rdy;
  assign rb = a[1] ? (a[0] ? dmem_rsp_data[31:24] : dmem_rsp_data[23:16])
                   : (a[0] ? dmem_rsp_data[15:8] : dmem_rsp_data[7:0]);
  assign rh = a[1] ? dmem_rsp_data[31:16] : dmem_rsp_data[15:0];
  assign ld_data = pkt_q.mem_sz == SZ_B ? {{24{pkt_q.sgnd & rb[7]}}, rb}
                 : pkt_q.mem_sz == SZ_H ? {{16{pkt_q.sgnd & rh[15]}}, rh} : dmem_rsp_data;
  assign be = pkt_q.mem_sz == SZ_B ? 4'b0001 << a
            : pkt_q.mem_sz == SZ_H ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata = pkt_q.mem_sz == SZ_B ? {4{pkt_q.data[7:0]}}
               : pkt_q.mem_sz == SZ_H ? {2{pkt_q.data[15:0]}} : pkt_q.data;
  assign dmem_req_vld = state == REQ && !mis;
  assign dmem_req_we = dmem_req_vld && pkt_q.mem_op == MEM_ST;
  assign dmem_req_addr = dmem_req_vld ? {pkt_q.addr[31:2], 2'b00} : '0;
  assign dmem_req_be = dmem_req_vld ? be : '0;
  assign dmem_req_wdata = dmem_req_vld ? wdata : '0;
  assign mem_wb_vld = state == OUT;
  assign mem_wb_pkt = mem_wb_vld ? {pkt_q.dst_vld, pkt_q.dst_reg, pkt_q.data} : '0;
  assign mem_haz_pkt = {state != IDLE && pkt_q.dst_vld, state != IDLE ? pkt_q.dst_reg : 5'd0,
                        (state == REQ || state == RSP) && is_ld};
  assign mem_fet_redir_vld = acc_q && pkt_q.jmp_vld;
  assign mem_fet_redir_addr = mem_fet_redir_vld ? pkt_q.addr : '0;
  // next state: accept wins in IDLE/OUT, otherwise advance on the dmem/writeback handshakes
  always_comb
    state_d = acc ? (exec_mem_pkt.mem_op == MEM_NONE ? OUT : REQ)
            : state == REQ ? (mis ? OUT : dmem_req_rdy ? (is_ld ? RSP : OUT) : REQ)
            : state == RSP ? (dmem_rsp_vld ? OUT : RSP)
            : state == OUT ? (mem_wb_rdy ? IDLE : OUT) : state;
  // state register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_d;
  // packet register: load on accept, kill dst for stores/traps, capture load lane on response
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) pkt_q <= '0;
    else if (acc) pkt_q <= exec_mem_pkt;
    else if (state == REQ && (mis || (dmem_req_rdy && !is_ld))) pkt_q.dst_vld <= 1'b0;
    else if (state == RSP && dmem_rsp_vld) pkt_q.data <= ld_data;
  // marks the cycle right after an accept so a jump redirects exactly once
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) acc_q <= 1'b0;
    else acc_q <= acc;
endmodule

// File: doc/mem_stg.md
# mem_stg

Memory stage of the MIPS pipeline and the consumer end of the `exec_mem` interface. It accepts one `exec_mem_pkg::exec_mem_pkt_t` per handshake and carries out byte, half or word loads and stores on a ready/valid data-memory port with variable latency. It forwards results to writeback on the `mem_wb` handshake and signals load-pending hazards to the hazard unit.

## Interface
- No parameters.
- `clk` in 1: clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `exec_mem_vld` in 1: packet valid from the exec stage.
- `exec_mem_rdy` out 1: stage can accept a packet.
- `exec_mem_pkt` in `exec_mem_pkt_t`: fields `jmp_vld`, `addr`, `mem_op` (MEM_NONE/MEM_LD/MEM_ST), `mem_sz` (SZ_B/SZ_H/SZ_W), `sgnd`, `dst_vld`, `dst_reg`, `data`. For MEM_ST, `data` holds the store data and `addr` holds the effective address.
- `dmem_req_vld` out 1, `dmem_req_rdy` in 1: data-memory request handshake.
- `dmem_req_we` out 1: 1 = store.
- `dmem_req_addr` out 32: word-aligned address (`addr[31:2]`, 2'b00).
- `dmem_req_be` out 4: byte enables.
- `dmem_req_wdata` out 32: lane-replicated store data.
- `dmem_rsp_vld` in 1, `dmem_rsp_data` in 32: load response. No backpressure on responses.
- `mem_wb_vld` out 1, `mem_wb_rdy` in 1, `mem_wb_pkt` out {`dst_vld`, `dst_reg`[4:0], `data`[31:0]}: writeback handshake.
- `mem_haz_pkt` out {`dst_vld`, `dst_reg`, `ld_pend`}: hazard unit feed.
- `mem_fet_redir_vld` out 1, `mem_fet_redir_addr` out 32: one-cycle branch/jump redirect to fetch.
- `mem_exc_vld` out 1, `mem_exc_addr` out 32: misalignment exception (see Configuration).

## Operation
- FSM states: IDLE, REQ, RSP, OUT. Reset state is IDLE. Every output resets to 0.
- `exec_mem_rdy` = (state==IDLE) | (state==OUT & `mem_wb_rdy`).
- On accept, the packet is latched into `pkt_q`. Next state:
  - MEM_NONE: OUT.
  - MEM_LD or MEM_ST: REQ.
- REQ:
  - `dmem_req_vld`=1 and the request fields are held stable until `dmem_req_rdy`.
  - On acceptance, a load goes to RSP. A store goes to OUT with `mem_wb_pkt.dst_vld`=0.
- RSP:
  - `dmem_rsp_vld` is sampled only in this state.
  - On response, the extracted lane is registered into `pkt_q.data` and the state moves to OUT.
- OUT:
  - `mem_wb_vld`=1.
  - If `mem_wb_rdy`: go to IDLE, or reload directly if `exec_mem_vld` is high in the same cycle (back-to-back).
- Lanes are little-endian; `a` = `addr[1:0]`.
  - Stores:
    - SZ_B: be = 1<<a, wdata = {4{data[7:0]}}.
    - SZ_H: be = a[1] ? 4'b1100 : 4'b0011, wdata = {2{data[15:0]}}.
    - SZ_W: be = 4'b1111.
  - Loads: extract byte `a`, halfword `a[1]`, or the full word. Sign-extend when `sgnd`, otherwise zero-extend.
- `mem_haz_pkt`:
  - `dst_vld`/`dst_reg` mirror `pkt_q` whenever state != IDLE.
  - `ld_pend`=1 in REQ and RSP for loads, meaning data is not yet forwardable.
- Redirect: a registered one-cycle pulse in the cycle after accepting a packet with `jmp_vld`. `mem_fet_redir_addr` = `pkt_q.addr`.

## Timing
- Accept cycle N:
  - Non-mem packet: `mem_wb_vld` at N+1.
  - Store: `dmem_req_vld` at N+1. If accepted at N+1, `mem_wb_vld` at N+2.
  - Load: request at N+1. Response no earlier than N+2. `mem_wb_vld` one cycle after the response.
- Throughput: one non-mem packet per cycle while `mem_wb_rdy` stays high.
- A `dmem_rsp_vld` outside RSP is ignored.
- An asynchronous reset mid-transaction drops the packet, returns to IDLE and clears all outputs. A late response arriving after reset is ignored.
- Simultaneous OUT drain and new accept: the output register is overwritten in the same edge, with no bubble.

## Configuration
- `MEM_STG_ALIGN_CHK_EN` defined:
  - A misaligned access (SZ_H with a[0]=1, or SZ_W with a!=0) issues no dmem request.
  - The FSM goes REQ→OUT without asserting `dmem_req_vld`, with `dst_vld`=0.
  - `mem_exc_vld` pulses for 1 cycle with `mem_exc_addr` = addr.
- Undefined:
  - The low address bits are ignored for lane selection: SZ_W uses lane 0, SZ_H uses `a[1]`.
  - `mem_exc_vld`/`mem_exc_addr` are tied to 0.

## Test plan
- ALU packet, dst_reg=5, data=0x1234, `mem_wb_rdy`=1 -> `mem_wb_vld` next cycle with dst 5, data 0x1234; no dmem request.
- SB addr=0x103, data=0x000000AB -> be=4'b1000, wdata=0xABABABAB, addr=0x100, we=1; `mem_wb` dst_vld=0.
- LH sgnd addr=0x202, rsp=0x8001_0000, `dmem_req_rdy` delayed 3 cycles and rsp 2 cycles -> data=0xFFFF8001; `ld_pend` high throughout the wait; `exec_mem_rdy`=0 meanwhile.
- LBU addr=0x1, rsp=0x0000_F000, `mem_wb_rdy` held low 4 cycles -> data=0xF0, held stable while stalled.
- jmp_vld packet, addr=0x400 -> `mem_fet_redir_vld` pulse for exactly one cycle with addr 0x400.
- Reset asserted in RSP, then a stray rsp -> all outputs 0, state IDLE, no `mem_wb_vld`. With `MEM_STG_ALIGN_CHK_EN`, LW at 0x6 -> `mem_exc_vld` pulse, no dmem request.
